// File: rtl/filter_pad_scheduler_pkg.sv
// Shared types and geometry helpers for the filter padding scheduler.
// Padded raster is (height+2B) x (width+2B) with B = (kernelSize-1)/2.
package isp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PAD,
        DATA,
        DONE
    } pad_state_t;

    localparam int DEF_WIDTH  = 320;
    localparam int DEF_HEIGHT = 240;
    localparam int DEF_KERNEL = 3;

    function automatic int boundary(input int kernelSize);
        return (kernelSize - 1) / 2;
    endfunction

    function automatic int padDim(input int n, input int kernelSize);
        return n + 2 * boundary(kernelSize);
    endfunction

    localparam int PAD_W2 = padDim(DEF_WIDTH, DEF_KERNEL);
    localparam int PAD_H2 = padDim(DEF_HEIGHT, DEF_KERNEL);

endpackage

// File: rtl/filter_pad_scheduler_if.sv
// Pixel stream bundle between the demosaic source, the scheduler
// and filter_fifo; master is the scheduler side.
interface filter_pad_scheduler_if #(
    parameter int dataWidth = 24
);
    logic                 iValid;
    logic                 oReady;
    logic [dataWidth-1:0] iData;
    logic                 oValid;
    logic [dataWidth-1:0] oData;
    logic                 oSof;
    logic                 oEol;

    modport master (
        input  iValid, iData,
        output oReady, oValid, oData, oSof, oEol
    );

    modport slave (
        output iValid, iData,
        input  oReady, oValid, oData, oSof, oEol
    );
endinterface

// File: rtl/filter_pad_scheduler_raster.sv
// Column/row position within the padded raster, with lookahead
// telling whether the next position lands on an active pixel.
module raster_counter
    import isp_pkg::*;
#(
    parameter int width  = DEF_WIDTH,
    parameter int height = DEF_HEIGHT,
    parameter int border = boundary(DEF_KERNEL),
    parameter int padW2  = PAD_W2,
    parameter int padH2  = PAD_H2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic lastCol,
    output logic lastRow,
    output logic isFirst,
    output logic nextActive
);
    localparam int CW = $clog2(padW2);
    localparam int RW = $clog2(padH2);

    localparam logic [CW-1:0] COL_LAST = CW'(padW2 - 1);
    localparam logic [CW-1:0] COL_LO   = CW'(border);
    localparam logic [CW-1:0] COL_HI   = CW'(border + width);
    localparam logic [RW-1:0] ROW_LAST = RW'(padH2 - 1);
    localparam logic [RW-1:0] ROW_LO   = RW'(border);
    localparam logic [RW-1:0] ROW_HI   = RW'(border + height);

    logic [CW-1:0] col;
    logic [CW-1:0] nCol;
    logic [RW-1:0] row;
    logic [RW-1:0] nRow;

    assign lastCol = col == COL_LAST;
    assign lastRow = row == ROW_LAST;
    assign isFirst = (col == '0) && (row == '0);

    always_comb begin
        nCol = lastCol ? '0 : col + 1'b1;
        nRow = row;
        if (lastCol) nRow = lastRow ? '0 : row + 1'b1;
    end

    assign nextActive = (nRow >= ROW_LO) && (nRow < ROW_HI)
                     && (nCol >= COL_LO) && (nCol < COL_HI);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            col <= nCol;
            row <= nRow;
        end
    end
endmodule

// File: rtl/filter_pad_scheduler.sv
// Emits the zero-padded raster for filter_fifo, throttling the
// upstream pixel stream so active pixels land inside the border.
module filter_pad_scheduler
    import isp_pkg::*;
#(
    parameter int width      = DEF_WIDTH,
    parameter int height     = DEF_HEIGHT,
    parameter int kernelSize = DEF_KERNEL,
    parameter int dataWidth  = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iStart,
    filter_pad_scheduler_if.master bus,
    output logic        oDone,
    output logic        oBusy,
    output logic [15:0] oFrameCnt
);
    pad_state_t state;
    pad_state_t nextState;

    logic advance;
    logic emitData;
    logic startAcc;
    logic finish;
    logic lastCol;
    logic lastRow;
    logic isFirst;
    logic nextActive;
    logic [dataWidth-1:0] beatData;

    raster_counter #(
        .width  (width),
        .height (height),
        .border (boundary(kernelSize)),
        .padW2  (padDim(width, kernelSize)),
        .padH2  (padDim(height, kernelSize))
    ) uRaster (
        .clk        (clk),
        .reset      (reset),
        .clear      (startAcc),
        .advance    (advance),
        .lastCol    (lastCol),
        .lastRow    (lastRow),
        .isFirst    (isFirst),
        .nextActive (nextActive)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (startAcc) nextState = PAD;
            PAD: begin
                if (lastCol && lastRow) nextState = DONE;
                else if (nextActive)    nextState = DATA;
            end
            DATA: if (bus.iValid && !nextActive) nextState = PAD;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // A start landing on the oDone cycle is dropped, not queued.
    always_comb begin
        startAcc = (state == IDLE) && iStart && !oDone;
        emitData = (state == DATA) && bus.iValid;
        advance  = (state == PAD) || emitData;
        finish   = state == DONE;
        beatData = emitData ? bus.iData : '0;
    end

    assign bus.oReady = state == DATA;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.oValid <= 1'b0;
            bus.oData  <= '0;
            bus.oSof   <= 1'b0;
            bus.oEol   <= 1'b0;
            oDone      <= 1'b0;
            oBusy      <= 1'b0;
            oFrameCnt  <= '0;
        end else begin
            bus.oValid <= advance;
            bus.oData  <= beatData;
            bus.oSof   <= advance && isFirst;
            bus.oEol   <= advance && lastCol;
            oDone      <= finish;
            if (finish) oFrameCnt <= oFrameCnt + 16'd1;
            if (startAcc)    oBusy <= 1'b1;
            else if (finish) oBusy <= 1'b0;
        end
    end
endmodule

// File: doc/filter_pad_scheduler.md
Name: filter_pad_scheduler

Overview:
Sequences the demosaiced RGB stream into filter_fifo, replacing the ad-hoc padding counters in processing. It inserts zero rows above and below the frame and zero columns left and right of each row. Upstream is throttled with a ready signal, so the output is an exact (height+2B) x (width+2B) raster, where B = (kernelSize-1)/2. filter_fifo consumes that raster with no further bookkeeping.

Parameters:
width, 320, active pixels per row
height, 240, active rows per frame
kernelSize, 3, filter kernel size; odd, >= 3; B = (kernelSize-1)/2
dataWidth, 24, pixel width ({R,G,B})

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
iStart  in  1  start-of-frame request (newFrame)
iValid  in  1  upstream pixel valid
oReady  out  1  upstream handshake; a pixel is consumed when iValid & oReady
iData  in  dataWidth  upstream pixel
oValid  out  1  output beat valid (drives filter iValid)
oData  out  dataWidth  output pixel; zero on pad beats
oSof  out  1  high with the first output beat of a frame
oEol  out  1  high with the last beat of each padded row
oDone  out  1  one-cycle pulse after the last beat of the frame
oBusy  out  1  high from the cycle after an accepted iStart until oDone
oFrameCnt  out  16  completed frames; wraps at 65535 -> 0

Behaviour:
- Reset: state IDLE, counters 0; oReady, oValid, oSof, oEol, oDone, oBusy = 0; oData = 0; oFrameCnt = 0. Reset mid-frame abandons the frame with no oDone.
- Padded geometry: W2 = width+2B, H2 = height+2B. Counters col (0..W2-1) and row (0..H2-1).
- All outputs are registered; an output beat appears 1 cycle after the state/handshake that produces it.
- State machine:
  - IDLE: iStart -> PAD; row = col = 0.
  - PAD: one zero beat every cycle. Pad positions are row < B, row >= B+height, col < B, col >= B+width. When the next position is an active column in an active row -> DATA.
  - DATA: oReady = 1 (combinational from state). On iValid, emit iData and advance col. With iValid low, emit nothing (oValid = 0, bubble) and hold col. After col = B+width-1 -> PAD (right pad).
  - Last beat (row = H2-1, col = W2-1) -> DONE.
  - DONE: oDone = 1 for 1 cycle; oFrameCnt increments; -> IDLE.
- Counter advance: col advances per emitted beat and wraps at W2-1 to 0, incrementing row. oEol asserts on the beat with col = W2-1. oSof asserts on the beat with row = col = 0.
- oReady is 0 in every state except DATA. Upstream holds the pixel while oReady = 0.
- iStart while oBusy, or in DONE, is ignored; there is no queuing.
- iStart arriving in the same cycle as oDone is ignored.
- iValid outside DATA is not consumed.
- Total output beats per frame = H2*W2 exactly. Pad beats are back-to-back; only DATA bubbles stretch the frame.
- Minimum frame time = H2*W2 + 2 cycles (start + DONE).

Decomposition:
- Shared package isp_pkg: pad_state_t enum (IDLE, PAD, DATA, DONE); function boundary(kernelSize) = (kernelSize-1)/2; localparams PAD_W2, PAD_H2 derived from width, height and kernelSize.
- One sub-module, raster_counter: col/row counter with wrap, producing last_col, last_row and is_active flags from the parameters. The FSM stays in filter_pad_scheduler.

Test Plan:
- Config width=4, height=2, kernelSize=3, iValid always 1, pixels 1..8 after iStart:
  - Exactly 24 oValid beats, no gaps.
  - Beats 0-5 are zero; row 1 is 0,1,2,3,4,0; row 2 is 0,5,6,7,8,0; beats 18-23 are zero.
  - oSof on beat 0; oEol on beats 5, 11, 17, 23.
  - oDone 1 cycle after beat 23; oFrameCnt = 1.
- Same config, iValid low for 3 cycles before pixel 3 -> oValid drops for exactly 3 cycles inside row 1; total beat count is still 24; data order is unchanged.
- Track oReady across the frame -> oReady high exactly 8 cycles-with-iValid in total; low during all 16 pad beats; 0 in IDLE.
- iStart pulsed again at beat 10 and in the oDone cycle -> both ignored, single frame, oFrameCnt = 1. iStart 1 cycle after oDone -> second frame starts, oFrameCnt = 2 after it.
- kernelSize=5, width=4, height=2 -> 48 beats (6x8); first 16 beats zero; row 2 is 0,0,1,2,3,4,0,0.
- Reset asserted at beat 12 -> next cycle all outputs 0, no oDone, oFrameCnt = 0. New iStart produces a full, correct 24-beat frame.
